jpeg_fifo_level: RTL and testbench

- Parametrised synchronous FIFO; successor to the single-purpose output FIFO in the JPEG decoder.
- Adds four features: a fill-level output, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a software error-clear input.
- Sits between the IDCT/colour-convert stage and the output bus.
- Almost-full lets the upstream stage throttle early instead of stalling on accept_o.

---
 rtl/jpeg_fifo_defs.sv | 18 +
 rtl/jpeg_fifo_ram.sv | 25 ++
 rtl/jpeg_fifo_level.sv | 120 ++++++++++++
 tb/tb_jpeg_fifo_level.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/jpeg_fifo_defs.sv
// rtl/jpeg_fifo_defs.sv - shared defaults and types for the JPEG output FIFO
package jpeg_fifo_defs;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 4;

  // One extra bit so the count can represent a completely full FIFO.
  function automatic int count_w(input int addr_w);
    return addr_w + 1;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

endpackage

// File: rtl/jpeg_fifo_ram.sv
// rtl/jpeg_fifo_ram.sv - DEPTH x WIDTH register array, one write port, async read
module jpeg_fifo_ram #(
  parameter int WIDTH  = jpeg_fifo_defs::DEF_WIDTH,
  parameter int DEPTH  = jpeg_fifo_defs::DEF_DEPTH,
  parameter int ADDR_W = jpeg_fifo_defs::DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/jpeg_fifo_level.sv
// rtl/jpeg_fifo_level.sv - first-word fall-through FIFO with fill level,
// almost-full/empty thresholds and sticky overflow/underflow flags
module jpeg_fifo_level
  import jpeg_fifo_defs::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [WIDTH-1:0]    data_in_i,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic                flush_i,
  input  logic                clr_err_i,
  output logic [WIDTH-1:0]    data_out_o,
  output logic                accept_o,
  output logic                valid_o,
  output logic [ADDR_W:0]     level_o,
  output logic                almost_full_o,
  output logic                almost_empty_o,
  output logic                overflow_o,
  output logic                underflow_o
);

  localparam int COUNT_W = count_w(ADDR_W);
  localparam logic [COUNT_W-1:0] FULL_CNT   = COUNT_W'(DEPTH);
  localparam logic [COUNT_W-1:0] AFULL_CNT  = COUNT_W'(AFULL_LVL);
  localparam logic [COUNT_W-1:0] AEMPTY_CNT = COUNT_W'(AEMPTY_LVL);

  if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("jpeg_fifo_level: DEPTH must equal 2**ADDR_W");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
    $error("jpeg_fifo_level: AFULL_LVL out of range 1..DEPTH");
  end
  if (AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
    $error("jpeg_fifo_level: AEMPTY_LVL out of range 0..DEPTH-1");
  end

  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  err_flags_t         err_q, err_d;
  logic               wr_en, rd_en;
  logic               ovf_evt, unf_evt;

  assign accept_o       = (count_q != FULL_CNT);
  assign valid_o        = (count_q != '0);
  assign level_o        = count_q;
  assign almost_full_o  = (count_q >= AFULL_CNT);
  assign almost_empty_o = (count_q <= AEMPTY_CNT);
  assign overflow_o     = err_q.overflow;
  assign underflow_o    = err_q.underflow;

  // Flush discards the cycle's transfers, so the RAM write is gated too.
  always_comb begin
    wr_en    = push_i & accept_o & ~flush_i;
    rd_en    = pop_i & valid_o & ~flush_i;
    ovf_evt  = push_i & ~accept_o;
    unf_evt  = pop_i & ~valid_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // A new error event wins over a same-cycle clear.
      err_d.overflow  = (err_q.overflow & ~clr_err_i) | ovf_evt;
      err_d.underflow = (err_q.underflow & ~clr_err_i) | unf_evt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  jpeg_fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_out_o)
  );

endmodule

// File: tb/tb_jpeg_fifo_level.sv
// tb/tb_jpeg_fifo_level.sv - scoreboard bench for jpeg_fifo_level
module tb_jpeg_fifo_level;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] data_in_i = '0;
  logic       push_i = 1'b0, pop_i = 1'b0, flush_i = 1'b0, clr_err_i = 1'b0;
  logic [7:0] data_out_o;
  logic       accept_o, valid_o, almost_full_o, almost_empty_o, overflow_o, underflow_o;
  logic [4:0] level_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;

  jpeg_fifo_level dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .data_in_i      (data_in_i),
    .push_i         (push_i),
    .pop_i          (pop_i),
    .flush_i        (flush_i),
    .clr_err_i      (clr_err_i),
    .data_out_o     (data_out_o),
    .accept_o       (accept_o),
    .valid_o        (valid_o),
    .level_o        (level_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    int lvl;
    lvl = mq.size();
    chk("level", 32'(level_o), 32'(lvl));
    chk("valid", 32'(valid_o), 32'(lvl > 0));
    chk("accept", 32'(accept_o), 32'(lvl < 16));
    chk("almost_full", 32'(almost_full_o), 32'(lvl >= 12));
    chk("almost_empty", 32'(almost_empty_o), 32'(lvl <= 2));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    chk("underflow", 32'(underflow_o), 32'(m_unf));
    if (valid_o === 1'b1 && !rst_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL data: got %0h while scoreboard empty", data_out_o);
      end else begin
        chk("data", 32'(data_out_o), 32'(exp_q[0]));
        if (pop_i && !flush_i) void'(exp_q.pop_front());
      end
    end
  end

  // Drive one cycle; the reference model advances at the consuming edge.
  task automatic cycle(input bit p, input bit q, input logic [7:0] d,
                       input bit f = 1'b0, input bit c = 1'b0);
    bit full, empty;
    push_i = p; pop_i = q; data_in_i = d; flush_i = f; clr_err_i = c;
    @(posedge clk_i);
    full  = (mq.size() == 16);
    empty = (mq.size() == 0);
    if (f) begin
      mq.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_ovf = (m_ovf && !c) || (p && full);
      m_unf = (m_unf && !c) || (q && empty);
      if (q && !empty) void'(mq.pop_front());
      if (p && !full) begin
        mq.push_back(d);
        exp_q.push_back(d);
      end
    end
    #1;
  endtask

  task automatic fill_to(input int n, input logic [7:0] base);
    while (mq.size() < n) cycle(1'b1, 1'b0, base + 8'(mq.size()));
  endtask

  task automatic drain();
    while (mq.size() > 0) cycle(1'b0, 1'b1, 8'h00);
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    cycle(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(i));
    drain();
    cycle(1'b0, 1'b0, 8'h00);

    fill_to(16, 8'h20);
    cycle(1'b1, 1'b0, 8'hAA);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    fill_to(16, 8'h40);
    cycle(1'b1, 1'b0, 8'hAB, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drain();

    cycle(1'b1, 1'b1, 8'h5C);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drain();

    fill_to(16, 8'h60);
    cycle(1'b1, 1'b1, 8'h77);
    cycle(1'b0, 1'b0, 8'h00);
    drain();
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 100; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
            1'b0, ($urandom_range(0, 15) == 0));
    end

    drain();
    fill_to(7, 8'h90);
    cycle(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h31);
    cycle(1'b0, 1'b0, 8'h00);

    fill_to(6, 8'hB0);
    push_i = 1'b1;
    data_in_i = 8'h44;
    #2 rst_i = 1'b1;
    #1;
    chk("async_level", 32'(level_o), 32'd0);
    chk("async_valid", 32'(valid_o), 32'd0);
    chk("async_accept", 32'(accept_o), 32'd1);
    chk("async_aempty", 32'(almost_empty_o), 32'd1);
    push_i = 1'b0;
    mq.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    cycle(1'b1, 1'b0, 8'h12);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
